// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage access unit: access sizes, FSM states, reset values.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDone
  } state_e;

  localparam logic [31:0] RST_WORD = 32'h0000_0000;
  localparam logic [3:0]  RST_STRB = 4'b0000;
  localparam logic [15:0] RST_CNT  = 16'h0000;

  // Size 2'b11 is handled as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = lo[0];
      default: mis = |lo;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_unit_ls_align.sv
// Combinational byte-lane steering: store data replication/strobes and load extract/extend.
module ls_align
  import mem_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_lo_i,
  input  logic [31:0] st_data_i,
  input  logic        st_we_i,
  output logic [31:0] st_wdata_o,
  output logic [3:0]  st_wstrb_o,
  input  logic [1:0]  ld_size_i,
  input  logic [1:0]  ld_lo_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_wdata_o = st_data_i;
    st_wstrb_o = 4'b1111;
    case (st_size_i)
      SZ_BYTE: begin
        st_wdata_o = {4{st_data_i[7:0]}};
        st_wstrb_o = 4'b0001 << st_lo_i;
      end
      SZ_HALF: begin
        st_wdata_o = {2{st_data_i[15:0]}};
        st_wstrb_o = st_lo_i[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
    if (!st_we_i) begin
      st_wdata_o = RST_WORD;
      st_wstrb_o = RST_STRB;
    end
  end

  always_comb begin
    ld_byte = ld_word_i[7:0];
    case (ld_lo_i)
      2'd1:    ld_byte = ld_word_i[15:8];
      2'd2:    ld_byte = ld_word_i[23:16];
      2'd3:    ld_byte = ld_word_i[31:24];
      default: ld_byte = ld_word_i[7:0];
    endcase
    ld_half = ld_lo_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];

    case (ld_size_i)
      SZ_BYTE: ld_data_o = {{24{ld_byte[7] & ~ld_unsigned_i}}, ld_byte};
      SZ_HALF: ld_data_o = {{16{ld_half[15] & ~ld_unsigned_i}}, ld_half};
      default: ld_data_o = ld_word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: handshaked word-bus FSM that stalls the pipeline
// until each load/store completes, with timeout abort and misalignment detection.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MEMMemRead,
  input  logic        MEMMemWrite,
  input  logic [1:0]  MEMMemSize,
  input  logic        MEMMemUnsigned,
  input  logic [31:0] MEMALUOut,
  input  logic [31:0] MEMWrite_data,
  output logic [31:0] MEMRead_data,
  output logic        mem_stall,
  output logic        misalign,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  localparam bit          TimeoutEn   = (TIMEOUT != 0);
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  lo_q, lo_d;
  logic [31:0] ld_q, ld_d;
  logic [15:0] cnt_q, cnt_d;

  logic        access;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [31:0] ld_fmt;

  // Store lanes come from the live EX/MEM inputs; load formatting from the captured access.
  ls_align u_ls_align (
    .st_size_i    (MEMMemSize),
    .st_lo_i      (MEMALUOut[1:0]),
    .st_data_i    (MEMWrite_data),
    .st_we_i      (MEMMemWrite),
    .st_wdata_o   (st_wdata),
    .st_wstrb_o   (st_wstrb),
    .ld_size_i    (size_q),
    .ld_lo_i      (lo_q),
    .ld_unsigned_i(uns_q),
    .ld_word_i    (ld_q),
    .ld_data_o    (ld_fmt)
  );

  assign access = MEMMemRead | MEMMemWrite;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wstrb_d   = wstrb_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    uns_d     = uns_q;
    lo_d      = lo_q;
    ld_d      = ld_q;
    cnt_d     = cnt_q;
    mem_stall = 1'b0;
    misalign  = 1'b0;
    bus_err   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (access) begin
          if (is_misaligned(MEMMemSize, MEMALUOut[1:0])) begin
            misalign = 1'b1;
          end else begin
            mem_stall = 1'b1;
            addr_d    = {MEMALUOut[31:2], 2'b00};
            we_d      = MEMMemWrite;
            wstrb_d   = st_wstrb;
            wdata_d   = st_wdata;
            size_d    = MEMMemSize;
            uns_d     = MEMMemUnsigned;
            lo_d      = MEMALUOut[1:0];
            state_d   = StReq;
          end
        end
      end
      StReq: begin
        mem_stall = 1'b1;
        if (dmem_gnt) begin
          cnt_d   = RST_CNT;
          state_d = StWait;
        end
      end
      StWait: begin
        mem_stall = 1'b1;
        cnt_d     = cnt_q + 16'd1;
        if (dmem_rvalid) begin
          if (!we_q) begin
            ld_d = dmem_rdata;
          end
          state_d = StDone;
        end else if (TimeoutEn && (cnt_q == TimeoutLast)) begin
          bus_err = 1'b1;
          ld_d    = RST_WORD;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      addr_q  <= RST_WORD;
      we_q    <= 1'b0;
      wstrb_q <= RST_STRB;
      wdata_q <= RST_WORD;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      lo_q    <= 2'b00;
      ld_q    <= RST_WORD;
      cnt_q   <= RST_CNT;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      lo_q    <= lo_d;
      ld_q    <= ld_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dmem_req     = (state_q == StReq);
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wstrb   = wstrb_q;
  assign dmem_wdata   = wdata_q;
  assign MEMRead_data = misalign ? RST_WORD : ld_fmt;

endmodule
